// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one 7-bit ALU between two requesters.
// Optional per-requester grant counters are enabled by defining ALU_ARB_GRANT_CNT_EN.
module alu_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [6:0] a0,
    input  logic [6:0] b0,
    input  logic [1:0] op0,
    input  logic       req1,
    input  logic [6:0] a1,
    input  logic [6:0] b1,
    input  logic [1:0] op1,
    output logic       ack0,
    output logic       ack1,
    output logic [6:0] res,
    output logic       busy,
    output logic [6:0] alu_a,
    output logic [6:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [6:0] alu_y
`ifdef ALU_ARB_GRANT_CNT_EN
    ,
    output logic [7:0] gcnt0,
    output logic [7:0] gcnt1
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0] r_state;
    logic       r_gnt;
    logic       r_last;
    logic       r_ack0;
    logic       r_ack1;
    logic       r_busy;
    logic [6:0] r_res;
    logic [6:0] r_alu_a;
    logic [6:0] r_alu_b;
    logic [1:0] r_alu_op;

    logic       w_win;
    logic [6:0] w_a;
    logic [6:0] w_b;
    logic [1:0] w_op;

    // Winner selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        w_win = 1'b0;
        if (req0 && req1) begin
            w_win = ~r_last;
        end else begin
            w_win = req1;
        end
    end

    // Operand mux for the selected winner.
    always_comb begin
        w_a  = a0;
        w_b  = b0;
        w_op = op0;
        if (w_win) begin
            w_a  = a1;
            w_b  = b1;
            w_op = op1;
        end else begin
            w_a  = a0;
            w_b  = b0;
            w_op = op0;
        end
    end

    // Main control FSM: IDLE samples and grants, EXEC captures the ALU, RESP acknowledges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= 1'b0;
            r_last   <= 1'b1;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_busy   <= 1'b0;
            r_res    <= 7'd0;
            r_alu_a  <= 7'd0;
            r_alu_b  <= 7'd0;
            r_alu_op <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    if (req0 || req1) begin
                        r_gnt    <= w_win;
                        r_alu_a  <= w_a;
                        r_alu_b  <= w_b;
                        r_alu_op <= w_op;
                        r_busy   <= 1'b1;
                        r_state  <= ST_EXEC;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    r_res   <= alu_y;
                    r_ack0  <= ~r_gnt;
                    r_ack1  <= r_gnt;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_last  <= r_gnt;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_GRANT_CNT_EN
    logic [7:0] r_gcnt0;
    logic [7:0] r_gcnt1;

    // Saturating grant counters, bumped as each response completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gcnt0 <= 8'd0;
            r_gcnt1 <= 8'd0;
        end else if (r_state == ST_RESP) begin
            if (r_gnt) begin
                if (r_gcnt1 != 8'd255) begin
                    r_gcnt1 <= r_gcnt1 + 8'd1;
                end else begin
                    r_gcnt1 <= r_gcnt1;
                end
            end else begin
                if (r_gcnt0 != 8'd255) begin
                    r_gcnt0 <= r_gcnt0 + 8'd1;
                end else begin
                    r_gcnt0 <= r_gcnt0;
                end
            end
        end else begin
            r_gcnt0 <= r_gcnt0;
            r_gcnt1 <= r_gcnt1;
        end
    end

    assign gcnt0 = r_gcnt0;
    assign gcnt1 = r_gcnt1;
`endif

    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign res    = r_res;
    assign busy   = r_busy;
    assign alu_a  = r_alu_a;
    assign alu_b  = r_alu_b;
    assign alu_op = r_alu_op;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter with a behavioural ALU model.
module tb_alu_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       req0;
    logic [6:0] a0;
    logic [6:0] b0;
    logic [1:0] op0;
    logic       req1;
    logic [6:0] a1;
    logic [6:0] b1;
    logic [1:0] op1;
    logic       ack0;
    logic       ack1;
    logic [6:0] res;
    logic       busy;
    logic [6:0] alu_a;
    logic [6:0] alu_b;
    logic [1:0] alu_op;
    logic [6:0] alu_y;
`ifdef ALU_ARB_GRANT_CNT_EN
    logic [7:0] gcnt0;
    logic [7:0] gcnt1;
`endif

    int n_checks;
    int n_errors;

    alu_rr_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .a0     (a0),
        .b0     (b0),
        .op0    (op0),
        .req1   (req1),
        .a1     (a1),
        .b1     (b1),
        .op1    (op1),
        .ack0   (ack0),
        .ack1   (ack1),
        .res    (res),
        .busy   (busy),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_y  (alu_y)
`ifdef ALU_ARB_GRANT_CNT_EN
        ,
        .gcnt0  (gcnt0),
        .gcnt1  (gcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: ADD, SUB, NAND, rotate-left-by-one of A.
    always_comb begin
        case (alu_op)
            2'b00:   alu_y = alu_a + alu_b;
            2'b01:   alu_y = alu_a - alu_b;
            2'b10:   alu_y = ~(alu_a & alu_b);
            2'b11:   alu_y = {alu_a[5:0], alu_a[6]};
            default: alu_y = 7'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " ack0"}, ack0, 0);
        check({tag, " ack1"}, ack1, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " res"}, res, 0);
        check({tag, " alu_a"}, alu_a, 0);
        check({tag, " alu_b"}, alu_b, 0);
        check({tag, " alu_op"}, alu_op, 0);
    endtask

    int n_ack;
    int n_ack0;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        req0 = 1'b0; a0 = 7'd0; b0 = 7'd0; op0 = 2'd0;
        req1 = 1'b0; a1 = 7'd0; b1 = 7'd0; op1 = 2'd0;
        step();
        step();
        check_idle_zero("por");
        rst = 1'b0;

        // Reset held two cycles mid-EXEC discards the operation.
        req0 = 1'b1; a0 = 7'd10; b0 = 7'd2; op0 = 2'b01;
        step();
        check("rst pre busy", busy, 1);
        rst = 1'b1;
        step();
        step();
        check_idle_zero("mid rst");
        rst = 1'b0;
        step();
        check("rst e0 busy", busy, 1);
        check("rst e0 alu_a", alu_a, 10);
        check("rst e0 alu_op", alu_op, 1);
        check("rst e0 ack0", ack0, 0);
        step();
        check("rst e1 ack0", ack0, 1);
        check("rst e1 res", res, 8);
        req0 = 1'b0;
        step();
        check("rst e2 ack0", ack0, 0);
        check("rst e2 busy", busy, 0);

        // Fresh reset, then simultaneous requests: req0 first.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; a0 = 7'h05; b0 = 7'h03; op0 = 2'b00;
        req1 = 1'b1; a1 = 7'd20; b1 = 7'd6;  op1 = 2'b01;
        step();
        check("tie alu_a", alu_a, 5);
        check("tie alu_b", alu_b, 3);
        step();
        check("tie ack0", ack0, 1);
        check("tie ack1 low", ack1, 0);
        check("tie res0", res, 8);
        req0 = 1'b0;
        step();
        check("tie e2 ack0", ack0, 0);
        check("tie e2 busy", busy, 0);
        step();
        check("tie g1 alu_a", alu_a, 20);
        check("tie g1 busy", busy, 1);
        step();
        check("tie ack1", ack1, 1);
        check("tie ack0 low", ack0, 0);
        check("tie res1", res, 14);
        req1 = 1'b0;
        step();
        check("tie end ack1", ack1, 0);

        // Single requester 0, NAND.
        req0 = 1'b1; a0 = 7'h55; b0 = 7'h0F; op0 = 2'b10;
        step();
        check("single ack0 e0", ack0, 0);
        check("single alu_op", alu_op, 2);
        step();
        check("single ack0", ack0, 1);
        check("single ack1", ack1, 0);
        check("single res", res, 7'h7A);
        req0 = 1'b0;
        step();
        check("single end ack0", ack0, 0);

        // Operand stability with ROL on requester 1.
        req1 = 1'b1; a1 = 7'b1000001; b1 = 7'd0; op1 = 2'b11;
        step();
        check("rol alu_a", alu_a, 7'b1000001);
        a1 = 7'h7F;
        step();
        check("rol ack1", ack1, 1);
        check("rol res", res, 7'b0000011);
        req1 = 1'b0;
        step();
        check("rol end ack1", ack1, 0);

        // Fairness: both held, acks alternate every third cycle.
        req0 = 1'b1; a0 = 7'd1; b0 = 7'd1; op0 = 2'b00;
        req1 = 1'b1; a1 = 7'd9; b1 = 7'd4; op1 = 2'b01;
        n_ack = 0;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (ack0 || ack1) begin
                check("fair cycle", c, 2 + 3 * n_ack);
                check("fair ack0", ack0, (n_ack % 2) == 0);
                check("fair ack1", ack1, (n_ack % 2) == 1);
                check("fair res", res, ((n_ack % 2) == 0) ? 2 : 5);
                n_ack++;
            end
        end
        check("fair count", n_ack, 4);
        req0 = 1'b0;
        req1 = 1'b0;
        step();

`ifdef ALU_ARB_GRANT_CNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("gcnt0 rst", gcnt0, 0);
        check("gcnt1 rst", gcnt1, 0);
        req0 = 1'b1; a0 = 7'd3; b0 = 7'd4; op0 = 2'b00;
        n_ack0 = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (ack0) n_ack0++;
            if (n_ack0 == 300) break;
        end
        check("gcnt grants", n_ack0, 300);
        req0 = 1'b0;
        step();
        check("gcnt0 sat", gcnt0, 255);
        check("gcnt1 same", gcnt1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("gcnt0 clr", gcnt0, 0);
        check("gcnt1 clr", gcnt1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Shares the single 7-bit ALU (ADD/SUB/NAND/ROL datapath) between two requesters using round-robin arbitration. It drives the ALU operand and opcode inputs from registers, captures the ALU result after one settle cycle, and returns it to the granted requester with a one-cycle acknowledge. It sits between requesting controllers and the ALU, in place of a single fixed controller.

## Interface
- No parameters; operand width fixed at 7, opcode width fixed at 2.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 request, level, held with operands until ack0
- a0  in  7  requester 0 operand A
- b0  in  7  requester 0 operand B
- op0  in  2  requester 0 opcode, passed to ALU unmodified
- req1, a1, b1, op1  in  1/7/7/2  requester 1, same meaning
- ack0  out  1  one-cycle pulse: res valid for requester 0
- ack1  out  1  one-cycle pulse: res valid for requester 1
- res  out  7  registered ALU result, valid while ack0 or ack1 high
- busy  out  1  high when state is not IDLE
- alu_a  out  7  registered operand A to ALU
- alu_b  out  7  registered operand B to ALU
- alu_op  out  2  registered opcode to ALU
- alu_y  in  7  combinational ALU result

## Operation
- States: IDLE, EXEC, RESP. Encoding is implementation choice.
- IDLE: no req -> stay. Any req -> choose winner, load alu_a/alu_b/alu_op from winner's operands, record winner in gnt, go EXEC.
- Arbitration: one req -> that one wins. Both -> the requester not equal to last wins. last <= gnt on leaving RESP.
- EXEC: res <= alu_y; go RESP. Operand inputs are ignored in EXEC/RESP (only the IDLE-sampled values are used).
- RESP: ack of gnt high, other ack low; go IDLE.
- Requester rule: after seeing ack high, requester drops req or presents new operands on the next cycle; req high in IDLE is always a new request.
- Opcode semantics belong to the ALU; arbiter never decodes op.
- Reset (any state, including mid-EXEC/RESP): state IDLE, ack0=ack1=0, res=0, alu_a=alu_b=0, alu_op=0, busy=0, last=1 (req0 wins first tie). In-flight operation discarded, no ack issued.

## Timing
- Edge E0: req sampled in IDLE -> alu_* valid after E0.
- Edge E1: alu_y captured into res -> ackN and res valid for the cycle after E1.
- Edge E2: ack drops, state IDLE; a waiting req granted at E3.
- Request-to-ack latency: 2 cycles; issue rate: 1 operation per 3 cycles.
- Under continuous req0=req1=1, grants alternate 0,1,0,1...; neither starves.
- busy rises after E0, falls after E2.
- ALU combinational path alu_a/alu_b/alu_op -> alu_y must settle within one clock.

## Configuration
- ALU_ARB_GRANT_CNT_EN defined: adds outputs gcnt0, gcnt1 (8 bits each), incremented on the RESP cycle of the respective grant, saturating at 255, cleared to 0 by rst.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset: hold rst 2 cycles mid-EXEC -> all outputs 0, busy 0, no ack; next req0 granted normally.
- Single request: req0=1, a0=7'h05, b0=7'h03, op0=2'b00 with ALU model ADD -> ack0 pulse 2 cycles after sample, res=7'h08, ack1 stays 0.
- Tie after reset: req0=req1=1 same cycle -> req0 served first, then req1 3 cycles later; res values match each requester's operands.
- Fairness: both req held 12 cycles -> 4 acks alternating ack0, ack1, ack0, ack1, one per 3 cycles.
- Operand stability: change a1 during EXEC -> res reflects the IDLE-sampled a1; ROL op 2'b11, a1=7'b1000001 -> res per ALU model 7'b0000011.
- With ALU_ARB_GRANT_CNT_EN: 300 grants to requester 0 -> gcnt0=255, gcnt1 unchanged; rst clears both.
